// File: rtl/ex_muldiv_ctrl_if.sv
// EX-stage <-> multiply/divide sequencer bundle: request, HI/LO access and status.
// master is the EX/decode side and slave is the sequencer.
interface ex_muldiv_ctrl_if #(
   parameter int DATA_W = 32
);
   logic              start;
   logic [1:0]        op;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic              rd_hi;
   logic              rd_lo;
   logic              wr_hi;
   logic              wr_lo;
   logic [DATA_W-1:0] wdata;
   logic              flush;
   logic [DATA_W-1:0] hi;
   logic [DATA_W-1:0] lo;
   logic              busy;
   logic              stall;
   logic              div0;

   modport master (
      output start, op, op_a, op_b, rd_hi, rd_lo, wr_hi, wr_lo, wdata, flush,
      input  hi, lo, busy, stall, div0
   );

   modport slave (
      input  start, op, op_a, op_b, rd_hi, rd_lo, wr_hi, wr_lo, wdata, flush,
      output hi, lo, busy, stall, div0
   );
endinterface

// File: rtl/ex_muldiv_ctrl.sv
// Iterative multiply/divide sequencer with HI/LO ownership for the EX stage.
// Optional build macro MULDIV_EARLY_OUT_EN: multiplies finish once the remaining multiplier bits are zero.
//
// state | meaning
// IDLE  | HI/LO serve MFHI/MFLO/MTHI/MTLO, a new mult/div may be accepted
// RUN   | one shift-add or restoring-divide iteration per cycle
// FIX   | sign correction and HI/LO write-back
module ex_muldiv_ctrl #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 5
) (
   input logic            clk,
   input logic            rst_n,
   ex_muldiv_ctrl_if.slave bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   logic [1:0]        state;
   logic [CNT_W-1:0]  cnt;
   logic              is_div;
   logic              neg_q;
   logic              neg_r;
   logic [DATA_W:0]   mag_a;
   logic [DATA_W:0]   mag_b;
   logic [DATA_W:0]   acc_hi;
   logic [DATA_W-1:0] acc_lo;
   logic [DATA_W-1:0] hi_q;
   logic [DATA_W-1:0] lo_q;
   logic              div0_q;

   logic              busy;
   logic              idle;
   logic              op_signed;
   logic              op_div;
   logic              a_neg;
   logic              b_neg;
   logic              b_zero;
   logic [DATA_W:0]   a_abs;
   logic [DATA_W:0]   b_abs;
   logic              do_start;
   logic              accept;
   logic              div_zero_hit;
   logic              do_wr_hi;
   logic              do_wr_lo;

   // request decode and operand magnitudes
   always_comb begin
      op_signed    = ~bus.op[0];
      op_div       = bus.op[1];
      a_neg        = op_signed & bus.op_a[DATA_W-1];
      b_neg        = op_signed & bus.op_b[DATA_W-1];
      a_abs        = a_neg ? -{1'b1, bus.op_a} : {1'b0, bus.op_a};
      b_abs        = b_neg ? -{1'b1, bus.op_b} : {1'b0, bus.op_b};
      b_zero       = (bus.op_b == '0);
      idle         = (state == S_IDLE);
      do_start     = idle & bus.start & ~bus.flush;
      div_zero_hit = do_start & op_div & b_zero;
      accept       = do_start & ~(op_div & b_zero);
      do_wr_hi     = idle & ~bus.flush & ~bus.start & bus.wr_hi;
      do_wr_lo     = idle & ~bus.flush & ~bus.start & bus.wr_lo;
   end

   logic [DATA_W:0]   mul_add;
   logic [DATA_W+1:0] mul_sum;
   logic [DATA_W:0]   mul_hi_nxt;
   logic [DATA_W-1:0] mul_lo_nxt;
   logic [DATA_W:0]   div_shift;
   logic [DATA_W:0]   div_diff;
   logic              div_ge;
   logic [DATA_W:0]   div_hi_nxt;
   logic [DATA_W-1:0] div_lo_nxt;
   logic              mul_done_early;
   logic              run_last;

   // one iteration of each datapath; product bits enter acc_lo from the top
   always_comb begin
      mul_add    = mag_b[0] ? mag_a : '0;
      mul_sum    = {1'b0, acc_hi} + {1'b0, mul_add};
      mul_hi_nxt = mul_sum[DATA_W+1:1];
      mul_lo_nxt = {mul_sum[0], acc_lo[DATA_W-1:1]};

      div_shift  = {acc_hi[DATA_W-1:0], acc_lo[DATA_W-1]};
      div_ge     = (div_shift >= mag_b);
      div_diff   = div_shift - mag_b;
      div_hi_nxt = div_ge ? div_diff : div_shift;
      div_lo_nxt = {acc_lo[DATA_W-2:0], div_ge};

`ifdef MULDIV_EARLY_OUT_EN
      mul_done_early = ~is_div & (mag_b[DATA_W:1] == '0);
`else
      mul_done_early = 1'b0;
`endif
      run_last = (cnt == CNT_LAST) | mul_done_early;
   end

   logic [CNT_W:0]      shamt;
   logic [2*DATA_W-1:0] prod_raw;
   logic [2*DATA_W-1:0] prod_fix;
   logic [DATA_W-1:0]   quo_fix;
   logic [DATA_W-1:0]   rem_fix;
   logic [DATA_W-1:0]   fix_hi;
   logic [DATA_W-1:0]   fix_lo;

   // an early-exited product still sits shifted left by the skipped iterations;
   // cnt wraps to zero after a full run, which means no realignment
   always_comb begin
`ifdef MULDIV_EARLY_OUT_EN
      shamt = (cnt == '0) ? '0 : ((CNT_W+1)'(DATA_W) - {1'b0, cnt});
`else
      shamt = '0;
`endif
      prod_raw = {acc_hi[DATA_W-1:0], acc_lo} >> shamt;
      prod_fix = neg_q ? -prod_raw : prod_raw;
      quo_fix  = neg_q ? -acc_lo : acc_lo;
      rem_fix  = neg_r ? -acc_hi[DATA_W-1:0] : acc_hi[DATA_W-1:0];
      fix_hi   = is_div ? rem_fix : prod_fix[2*DATA_W-1:DATA_W];
      fix_lo   = is_div ? quo_fix : prod_fix[DATA_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         cnt    <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         mag_a  <= '0;
         mag_b  <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  mag_a  <= a_abs;
                  mag_b  <= b_abs;
                  is_div <= op_div;
                  neg_q  <= a_neg ^ b_neg;
                  neg_r  <= a_neg;
                  acc_hi <= '0;
                  acc_lo <= op_div ? a_abs[DATA_W-1:0] : '0;
                  cnt    <= '0;
                  state  <= S_RUN;
               end
            end
            S_RUN: begin
               if (bus.flush) begin
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
                  if (is_div) begin
                     acc_hi <= div_hi_nxt;
                     acc_lo <= div_lo_nxt;
                  end else begin
                     acc_hi <= mul_hi_nxt;
                     acc_lo <= mul_lo_nxt;
                     mag_b  <= mag_b >> 1;
                  end
                  if (run_last) begin
                     state <= S_FIX;
                  end
               end
            end
            S_FIX: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // HI/LO and the sticky divide-by-zero flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q   <= '0;
         lo_q   <= '0;
         div0_q <= 1'b0;
      end else begin
         if (state == S_FIX && !bus.flush) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
         end else begin
            if (do_wr_hi) begin
               hi_q <= bus.wdata;
            end
            if (do_wr_lo) begin
               lo_q <= bus.wdata;
            end
         end
         if (div_zero_hit) begin
            div0_q <= 1'b1;
         end
      end
   end

   assign busy      = (state != S_IDLE);
   assign bus.busy  = busy;
   assign bus.stall = busy & (bus.start | bus.rd_hi | bus.rd_lo | bus.wr_hi | bus.wr_lo);
   assign bus.hi    = hi_q;
   assign bus.lo    = lo_q;
   assign bus.div0  = div0_q;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Bench for ex_muldiv_ctrl: arithmetic reference model checked every cycle
// plus directed vectors with literal expected results.
module tb_ex_muldiv_ctrl;
   localparam int W = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ex_muldiv_ctrl_if #(.DATA_W(W)) bus();

   ex_muldiv_ctrl #(.DATA_W(W), .CNT_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference arithmetic straight from the operation definitions
   function automatic void compute(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] h, output logic [W-1:0] l);
      longint      sa, sb, p, q, r;
      logic [63:0] up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      h  = '0;
      l  = '0;
      case (op)
         2'b00: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
         2'b01: begin up = {32'b0, a} * {32'b0, b}; h = up[63:32]; l = up[31:0]; end
         2'b10: begin q = sa / sb; r = sa % sb; h = r[31:0]; l = q[31:0]; end
         default: begin l = a / b; h = a % b; end
      endcase
   endfunction

   // cycles from acceptance until HI/LO are written
   function automatic int latency(input logic [1:0] op, input logic [W-1:0] b);
      logic [W-1:0] m;
      int           n;
      m = (!op[0] && b[W-1]) ? -b : b;
      n = 1;
      for (int i = 0; i < W; i++) if (m[i]) n = i + 1;
`ifdef MULDIV_EARLY_OUT_EN
      if (!op[1]) return n + 1;
`endif
      return (n > 0) ? W + 1 : 0;
   endfunction

   logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
   logic         m_div0 = 1'b0;
   int           m_left = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_hi = '0; m_lo = '0; m_div0 = 1'b0; m_left = 0;
      end else if (m_left > 0) begin
         if (bus.flush) m_left = 0;
         else begin
            m_left--;
            if (m_left == 0) begin m_hi = p_hi; m_lo = p_lo; end
         end
      end else if (!bus.flush) begin
         if (bus.start) begin
            if (bus.op[1] && bus.op_b == '0) m_div0 = 1'b1;
            else begin
               compute(bus.op, bus.op_a, bus.op_b, p_hi, p_lo);
               m_left = latency(bus.op, bus.op_b);
            end
         end else begin
            if (bus.wr_hi) m_hi = bus.wdata;
            if (bus.wr_lo) m_lo = bus.wdata;
         end
      end
   end

   always @(negedge clk) begin
      chk("model_hi", bus.hi, m_hi);
      chk("model_lo", bus.lo, m_lo);
      chk("model_busy", bus.busy, m_left > 0);
      chk("model_stall", bus.stall,
          (m_left > 0) && (bus.start | bus.rd_hi | bus.rd_lo | bus.wr_hi | bus.wr_lo));
      chk("model_div0", bus.div0, m_div0);
   end

   task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = op; bus.op_a = a; bus.op_b = b;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_idle(input string name, output int cycles);
      cycles = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!bus.busy) break;
         cycles++;
      end
      if (cycles >= 200) chk({name, "_timeout"}, 64'(cycles), 64'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

   int cyc;

   initial begin
      bus.start = 0; bus.op = 0; bus.op_a = 0; bus.op_b = 0;
      bus.rd_hi = 0; bus.rd_lo = 0; bus.wr_hi = 0; bus.wr_lo = 0;
      bus.wdata = 0; bus.flush = 0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_hi", bus.hi, 0);
      chk("rst_lo", bus.lo, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_div0", bus.div0, 0);

      issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_idle("multu_max", cyc);
      chk("multu_max_busy_cycles", cyc, 33);
      chk("multu_max_hi", bus.hi, 32'hFFFF_FFFE);
      chk("multu_max_lo", bus.lo, 32'h0000_0001);

      issue(2'b00, -32'sd6, 32'd7);
      wait_idle("mult_neg", cyc);
      chk("mult_neg_hi", bus.hi, 32'hFFFF_FFFF);
      chk("mult_neg_lo", bus.lo, 32'hFFFF_FFD6);

      issue(2'b10, -32'sd7, 32'd2);
      wait_idle("div_neg", cyc);
      chk("div_neg_lo", bus.lo, 32'hFFFF_FFFD);
      chk("div_neg_hi", bus.hi, 32'hFFFF_FFFF);

      issue(2'b11, 32'd100, 32'd0);
      wait_idle("divu_zero", cyc);
      chk("divu_zero_busy_cycles", cyc, 0);
      chk("divu_zero_div0", bus.div0, 1);
      chk("divu_zero_hi", bus.hi, 32'hFFFF_FFFF);
      chk("divu_zero_lo", bus.lo, 32'hFFFF_FFFD);

      issue(2'b11, 32'd100, 32'd7);
      wait_idle("divu", cyc);
      chk("divu_lo", bus.lo, 14);
      chk("divu_hi", bus.hi, 2);
      chk("divu_div0_sticky", bus.div0, 1);

      issue(2'b01, 32'd3, 32'd5);
      bus.rd_lo = 1'b1;
      cyc = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!bus.busy) break;
         cyc++;
         chk("mflo_stall_busy", bus.stall, 1);
      end
      if (cyc >= 200) chk("mflo_timeout", 64'(cyc), 0);
      chk("mflo_stall_idle", bus.stall, 0);
      chk("mflo_lo", bus.lo, 15);
      bus.rd_lo = 1'b0;

      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle("div_ovf", cyc);
      chk("div_ovf_lo", bus.lo, 32'h8000_0000);
      chk("div_ovf_hi", bus.hi, 0);

      issue(2'b10, 32'd100, 32'd3);
      repeat (9) @(posedge clk);
      #1 bus.flush = 1'b1;
      @(posedge clk); #1 bus.flush = 1'b0;
      chk("flush_run_busy", bus.busy, 0);
      chk("flush_run_hi", bus.hi, 0);
      chk("flush_run_lo", bus.lo, 32'h8000_0000);

      issue(2'b11, 32'd50, 32'd5);
      repeat (32) @(posedge clk);
      #1 bus.flush = 1'b1;
      @(posedge clk); #1 bus.flush = 1'b0;
      chk("flush_fix_busy", bus.busy, 0);
      chk("flush_fix_lo", bus.lo, 32'h8000_0000);

      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = 2'b01; bus.op_a = 2; bus.op_b = 2;
      bus.flush = 1'b1; bus.wr_lo = 1'b1; bus.wdata = 32'hAAAA;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.flush = 1'b0; bus.wr_lo = 1'b0;
      chk("flush_idle_busy", bus.busy, 0);
      chk("flush_idle_lo", bus.lo, 32'h8000_0000);

      issue(2'b01, 32'd3, 32'd5);
      repeat (4) @(posedge clk);
      bus.rd_hi = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_hi", bus.hi, 0);
      chk("async_rst_lo", bus.lo, 0);
      chk("async_rst_busy", bus.busy, 0);
      chk("async_rst_stall", bus.stall, 0);
      #3 rst_n = 1'b1;
      bus.rd_hi = 1'b0;

      @(posedge clk); #1;
      bus.wr_hi = 1'b1; bus.wdata = 32'h1234;
      @(posedge clk); #1;
      bus.wr_hi = 1'b0;
      chk("mthi", bus.hi, 32'h1234);

      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = 2'b01; bus.op_a = 4; bus.op_b = 4;
      bus.wr_hi = 1'b1; bus.wdata = 32'hDEAD;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.wr_hi = 1'b0;
      wait_idle("start_prio", cyc);
      chk("start_prio_hi", bus.hi, 0);
      chk("start_prio_lo", bus.lo, 16);

      issue(2'b00, 32'h8000_0000, 32'h8000_0000);
      wait_idle("mult_min", cyc);
      chk("mult_min_hi", bus.hi, 32'h4000_0000);
      chk("mult_min_lo", bus.lo, 0);

      issue(2'b10, 32'd7, -32'sd2);
      wait_idle("div_negb", cyc);
      chk("div_negb_lo", bus.lo, 32'hFFFF_FFFD);
      chk("div_negb_hi", bus.hi, 1);

      @(posedge clk); #1;
      bus.wr_lo = 1'b1; bus.wdata = 32'h5A5A_0001;
      @(posedge clk); #1;
      bus.wr_lo = 1'b0;
      chk("mtlo", bus.lo, 32'h5A5A_0001);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
